timer_scheduler: RTL and testbench

- Memory-mapped bus initiator that drives the lab timer peripheral in hardware rather than in software.
- Reads the current cycle count and programs the interrupt-cycle register to count+period.
- Waits for TimerInterrupt, acknowledges it, pulses a tick, then re-arms. This produces periodic interrupts with no CPU involvement.
- Sits between a simple control/status front end and the shared address/data/MemRead/MemWrite bus that the timer decodes.

---
 rtl/timer_scheduler.sv | 149 ++++++++++++++
 tb/tb_timer_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Hardware bus initiator that keeps the lab timer re-armed for periodic ticks.
// Optional one-shot mode is enabled by defining TIMER_SCHED_ONESHOT_EN.
module timer_scheduler #(
    parameter logic [31:0] TIMER_CYCLE_ADDR = 32'hffff001c,
    parameter logic [31:0] TIMER_ACK_ADDR   = 32'hffff006c,
    parameter int          COUNT_W          = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [31:0]        period,
    input  logic [31:0]        cycle,
    input  logic               TimerInterrupt,
`ifdef TIMER_SCHED_ONESHOT_EN
    input  logic               oneshot,
`endif
    output logic [31:0]        address,
    output logic [31:0]        data,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               tick,
    output logic               busy,
    output logic [COUNT_W-1:0] tick_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_WAIT,
        S_ACK,
        S_DISARM
    } state_t;

    state_t      state_q;
    logic [31:0] period_q;
    logic        stop_pending_q;
    logic        stop_pending_d;
`ifdef TIMER_SCHED_ONESHOT_EN
    logic        oneshot_q;
`endif

    // A stop seen this cycle counts as pending, so it is honoured at the end of WAIT or ACK.
    assign stop_pending_d = stop_pending_q | (stop & (state_q != S_IDLE));

    // NOTE: bus outputs are loaded on the transition into a state, so they are
    // registered yet line up with that state; every branch uses non-blocking updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            period_q       <= '0;
            stop_pending_q <= 1'b0;
            address        <= '0;
            data           <= '0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            tick           <= 1'b0;
            busy           <= 1'b0;
            tick_count     <= '0;
`ifdef TIMER_SCHED_ONESHOT_EN
            oneshot_q      <= 1'b0;
`endif
        end else begin
            address        <= '0;
            data           <= '0;
            MemRead        <= 1'b0;
            MemWrite       <= 1'b0;
            tick           <= 1'b0;
            stop_pending_q <= stop_pending_d;

            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        period_q   <= (period < 32'd2) ? 32'd2 : period;
                        tick_count <= '0;
`ifdef TIMER_SCHED_ONESHOT_EN
                        oneshot_q  <= oneshot;
`endif
                        state_q    <= S_READ;
                        busy       <= 1'b1;
                        MemRead    <= 1'b1;
                        address    <= TIMER_CYCLE_ADDR;
                    end
                end

                S_READ: begin
                    // The snapshot is taken here and folded straight into the compare value.
                    state_q  <= S_WRITE;
                    MemWrite <= 1'b1;
                    address  <= TIMER_CYCLE_ADDR;
                    data     <= cycle + period_q;
                end

                S_WRITE: begin
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (stop_pending_d) begin
                        state_q  <= S_DISARM;
                        MemWrite <= 1'b1;
                        address  <= TIMER_CYCLE_ADDR;
                        data     <= '1;
                    end else if (TimerInterrupt) begin
                        state_q    <= S_ACK;
                        MemWrite   <= 1'b1;
                        address    <= TIMER_ACK_ADDR;
                        tick       <= 1'b1;
                        tick_count <= tick_count + 1'b1;
                    end
                end

                S_ACK: begin
`ifdef TIMER_SCHED_ONESHOT_EN
                    if (oneshot_q) begin
                        state_q        <= S_IDLE;
                        busy           <= 1'b0;
                        stop_pending_q <= 1'b0;
                    end else
`endif
                    if (stop_pending_d) begin
                        state_q  <= S_DISARM;
                        MemWrite <= 1'b1;
                        address  <= TIMER_CYCLE_ADDR;
                        data     <= '1;
                    end else begin
                        state_q <= S_READ;
                        MemRead <= 1'b1;
                        address <= TIMER_CYCLE_ADDR;
                    end
                end

                S_DISARM: begin
                    state_q        <= S_IDLE;
                    busy           <= 1'b0;
                    stop_pending_q <= 1'b0;
                end

                default: begin
                    state_q        <= S_IDLE;
                    busy           <= 1'b0;
                    stop_pending_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed vector table, hand sequences,
// and randomized traffic against a phase-level reference model.
module tb_timer_scheduler;

    localparam logic [31:0] A_CYC = 32'hffff001c;
    localparam logic [31:0] A_ACK = 32'hffff006c;

    logic        clock = 1'b0;
    logic        reset, start, stop, TimerInterrupt;
    logic [31:0] period, cycle;
    logic [31:0] address, data;
    logic        MemRead, MemWrite, tick, busy;
    logic [15:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    timer_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .period         (period),
        .cycle          (cycle),
        .TimerInterrupt (TimerInterrupt),
        .address        (address),
        .data           (data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .tick           (tick),
        .busy           (busy),
        .tick_count     (tick_count)
    );

    // Observed outputs packed as {rd, wr, tick, busy, address, data, tick_count}.
    function automatic logic [83:0] observed();
        return {MemRead, MemWrite, tick, busy, address, data, tick_count};
    endfunction

    function automatic logic [83:0] pack(input logic rd, wr, tk, bz,
                                         input logic [31:0] ad, dt,
                                         input logic [15:0] cnt);
        return {rd, wr, tk, bz, ad, dt, cnt};
    endfunction

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rd=%b wr=%b tick=%b busy=%b addr=%h data=%h cnt=%0d, expected rd=%b wr=%b tick=%b busy=%b addr=%h data=%h cnt=%0d",
                     name, act[83], act[82], act[81], act[80], act[79:48], act[47:16], act[15:0],
                     exp[83], exp[82], exp[81], exp[80], exp[79:48], exp[47:16], exp[15:0]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, sp, ti, input logic [31:0] per, cyc);
        start = st; stop = sp; TimerInterrupt = ti; period = per; cycle = cyc;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, sp, ti;
        logic [31:0] per, cyc;
        logic [83:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, sp, ti, input logic [31:0] per, cyc,
                                input logic rd, wr, tk, bz,
                                input logic [31:0] ad, dt, input logic [15:0] cnt);
        vec_t v;
        v.st = st; v.sp = sp; v.ti = ti; v.per = per; v.cyc = cyc;
        v.exp = pack(rd, wr, tk, bz, ad, dt, cnt);
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {M_OFF, M_SAMPLE, M_PROGRAM, M_ARMED, M_ACKING, M_DISARMING} mphase_t;

    mphase_t     m_phase;
    bit          m_pend;
    logic [31:0] m_per, m_target;
    logic [15:0] m_cnt;

    function automatic void model_reset();
        m_phase = M_OFF; m_pend = 0; m_per = 0; m_target = 0; m_cnt = 0;
    endfunction

    // Advance one clock given the inputs present during that clock.
    function automatic void model_step(input bit st, sp, ti, input logic [31:0] per, cyc);
        mphase_t nxt = m_phase;
        bit pend = m_pend || (sp && m_phase != M_OFF);
        case (m_phase)
            M_OFF:       if (st && !sp) begin
                             m_per = (per < 2) ? 32'd2 : per;
                             m_cnt = 0;
                             nxt = M_SAMPLE;
                         end
            M_SAMPLE:    begin m_target = cyc + m_per; nxt = M_PROGRAM; end
            M_PROGRAM:   nxt = M_ARMED;
            M_ARMED:     if (pend) nxt = M_DISARMING; else if (ti) nxt = M_ACKING;
            M_ACKING:    nxt = pend ? M_DISARMING : M_SAMPLE;
            M_DISARMING: nxt = M_OFF;
            default:     nxt = M_OFF;
        endcase
        if (nxt == M_ACKING) m_cnt = m_cnt + 16'd1;
        m_pend  = (nxt == M_OFF) ? 1'b0 : pend;
        m_phase = nxt;
    endfunction

    function automatic logic [83:0] model_expect();
        case (m_phase)
            M_SAMPLE:    return pack(1, 0, 0, 1, A_CYC, 0, m_cnt);
            M_PROGRAM:   return pack(0, 1, 0, 1, A_CYC, m_target, m_cnt);
            M_ARMED:     return pack(0, 0, 0, 1, 0, 0, m_cnt);
            M_ACKING:    return pack(0, 1, 1, 1, A_ACK, 0, m_cnt);
            M_DISARMING: return pack(0, 1, 0, 1, A_CYC, 32'hffffffff, m_cnt);
            default:     return pack(0, 0, 0, 0, 0, 0, m_cnt);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        drive(1, 0, 1, 32'd5, 32'd10);

        // Reset held two cycles, then a quiet idle period.
        repeat (2) step();
        check("reset_state", observed(), '0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle_quiet%0d", i), observed(), '0);
        end

        // Basic arm, wrap, start-while-busy, stop in WRITE
        add(1,0,0, 5, 0,            1,0,0,1, A_CYC, 0, 0);
        add(0,0,0, 0, 10,           0,1,0,1, A_CYC, 32'h0000000f, 0);
        add(1,0,0, 9, 0,            0,0,0,1, 0, 0, 0);
        add(0,0,1, 0, 0,            0,1,1,1, A_ACK, 0, 1);
        add(0,0,0, 0, 0,            1,0,0,1, A_CYC, 0, 1);
        add(0,0,0, 0, 32'hfffffffe, 0,1,0,1, A_CYC, 32'h00000003, 1);
        add(0,1,0, 0, 0,            0,0,0,1, 0, 0, 1);
        add(0,0,0, 0, 0,            0,1,0,1, A_CYC, 32'hffffffff, 1);
        add(0,0,0, 0, 0,            0,0,0,0, 0, 0, 1);
        // start+stop together in IDLE, then period clamp, stop in WAIT
        add(1,1,0, 7, 0,            0,0,0,0, 0, 0, 1);
        add(1,0,0, 0, 0,            1,0,0,1, A_CYC, 0, 0);
        add(0,0,0, 0, 100,          0,1,0,1, A_CYC, 32'd102, 0);
        add(0,0,0, 0, 0,            0,0,0,1, 0, 0, 0);
        add(0,1,0, 0, 0,            0,1,0,1, A_CYC, 32'hffffffff, 0);
        add(0,0,0, 0, 0,            0,0,0,0, 0, 0, 0);
        // stop in READ: write completes, interrupt in WAIT loses to stop
        add(1,0,0, 4, 0,            1,0,0,1, A_CYC, 0, 0);
        add(0,1,0, 0, 32'hfffffffe, 0,1,0,1, A_CYC, 32'h00000002, 0);
        add(0,0,0, 0, 0,            0,0,0,1, 0, 0, 0);
        add(0,0,1, 0, 0,            0,1,0,1, A_CYC, 32'hffffffff, 0);
        add(0,0,0, 0, 0,            0,0,0,0, 0, 0, 0);
        // stop during ACK
        add(1,0,0, 3, 0,            1,0,0,1, A_CYC, 0, 0);
        add(0,0,0, 0, 7,            0,1,0,1, A_CYC, 32'd10, 0);
        add(0,0,0, 0, 0,            0,0,0,1, 0, 0, 0);
        add(0,0,1, 0, 0,            0,1,1,1, A_ACK, 0, 1);
        add(0,1,0, 0, 0,            0,1,0,1, A_CYC, 32'hffffffff, 1);
        add(0,0,0, 0, 0,            0,0,0,0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].ti, vecs[i].per, vecs[i].cyc);
            step();
            check($sformatf("vec%0d", i), observed(), vecs[i].exp);
        end

        // Reset in the middle of a WRITE aborts without ack or disarm.
        drive(1, 0, 0, 32'd5, 0);
        step();
        drive(0, 0, 0, 0, 32'd3);
        step();
        check("midop_write", observed(), pack(0, 1, 0, 1, A_CYC, 32'd8, 0));
        reset = 1'b1;
        drive(0, 0, 1, 0, 0);
        step();
        check("midop_reset", observed(), '0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midop_quiet%0d", i), observed(), '0);
        end

        // Randomized traffic against the reference model.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        r_st, r_sp, r_ti;
            logic [31:0] r_per, r_cyc;
            r_st  = ($urandom_range(0, 7) == 0);
            r_sp  = ($urandom_range(0, 15) == 0);
            r_ti  = ($urandom_range(0, 2) == 0);
            r_per = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8));
            r_cyc = ($urandom_range(0, 1) == 0) ? $urandom : (32'hfffffff0 + 32'($urandom_range(0, 15)));
            drive(r_st, r_sp, r_ti, r_per, r_cyc);
            model_step(r_st, r_sp, r_ti, r_per, r_cyc);
            step();
            check($sformatf("rand%0d", i), observed(), model_expect());
            if ((MemRead & MemWrite) !== 1'b0)
                check($sformatf("rd_wr_excl%0d", i), {82'd0, MemRead, MemWrite}, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
